// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bridge state encoding and
// a helper that classifies a response as error or success.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } sri2axi_state_t;

  // EXOKAY has no meaning for a single-beat non-exclusive access, so it
  // counts as success; only SLVERR/DECERR report an error upstream.
  function automatic logic resp_is_error(input logic [1:0] resp);
    logic err;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
      RESP_SLVERR, RESP_DECERR: err = 1'b1;
      default:                  err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/sri_to_axilite.sv
// SRI slave to AXI4-Lite master bridge. Each SRI request becomes exactly
// one AXI4-Lite transaction; one outstanding at a time. Every SRI and AXI
// output is driven straight from a register.
module sri_to_axilite
  import axi_lite_pkg::*;
#(
  parameter int SRI_ADDR_WIDTH = 20,
  parameter int SRI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sri_en_i,
  input  logic [SRI_ADDR_WIDTH-1:0]   sri_addr_i,
  input  logic                        sri_we_i,
  input  logic [SRI_DATA_WIDTH-1:0]   sri_wdata_i,
  input  logic [SRI_DATA_WIDTH/8-1:0] sri_be_i,
  output logic                        sri_ready_o,
  output logic [SRI_DATA_WIDTH-1:0]   sri_rdata_o,
  output logic                        sri_error_o,
  output logic [AXI_ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic                        m_awvalid_o,
  input  logic                        m_awready_i,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                        m_wvalid_o,
  input  logic                        m_wready_i,
  input  logic [1:0]                  m_bresp_i,
  input  logic                        m_bvalid_i,
  output logic                        m_bready_o,
  output logic [AXI_ADDR_WIDTH-1:0]   m_araddr_o,
  output logic                        m_arvalid_o,
  input  logic                        m_arready_i,
  input  logic [AXI_DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]                  m_rresp_i,
  input  logic                        m_rvalid_i,
  output logic                        m_rready_o
);

  sri2axi_state_t state_reg, state_next;

  // A single address register serves both AW and AR: only one of the two
  // channels is ever active for a given transaction.
  logic [AXI_ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [AXI_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_reg, wstrb_next;
  logic                        awvalid_reg, awvalid_next;
  logic                        wvalid_reg, wvalid_next;
  logic                        bready_reg, bready_next;
  logic                        arvalid_reg, arvalid_next;
  logic                        rready_reg, rready_next;
  logic                        sri_ready_reg, sri_ready_next;
  logic [SRI_DATA_WIDTH-1:0]   sri_rdata_reg, sri_rdata_next;
  logic                        sri_error_reg, sri_error_next;
  logic                        aw_pending, w_pending;

  // State register; reset abandons any in-flight AXI transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so the ports come straight from flops.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    sri_ready_next = 1'b0;
    sri_rdata_next = sri_rdata_reg;
    sri_error_next = sri_error_reg;
    aw_pending     = 1'b0;
    w_pending      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sri_en_i) begin
          addr_next = AXI_BASE_ADDR | AXI_ADDR_WIDTH'(sri_addr_i);
          if (sri_we_i) begin
            wdata_next   = AXI_DATA_WIDTH'(sri_wdata_i);
            wstrb_next   = (AXI_DATA_WIDTH/8)'(sri_be_i);
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = WR_REQ;
          end else begin
            arvalid_next = 1'b1;
            state_next   = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        // AW and W complete independently; a channel whose valid already
        // dropped has handshaken earlier.
        aw_pending   = awvalid_reg && !m_awready_i;
        w_pending    = wvalid_reg && !m_wready_i;
        awvalid_next = aw_pending;
        wvalid_next  = w_pending;
        if (!aw_pending && !w_pending) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_bvalid_i) begin
          bready_next    = 1'b0;
          sri_error_next = resp_is_error(m_bresp_i);
          sri_rdata_next = '0;
          sri_ready_next = 1'b1;
          state_next     = DONE;
        end
      end

      RD_REQ: begin
        if (m_arready_i) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (m_rvalid_i) begin
          rready_next    = 1'b0;
          sri_error_next = resp_is_error(m_rresp_i);
          sri_rdata_next = resp_is_error(m_rresp_i) ? '0 : SRI_DATA_WIDTH'(m_rdata_i);
          sri_ready_next = 1'b1;
          state_next     = DONE;
        end
      end

      // The completion pulse is on the ports this cycle; requests are
      // ignored until back in IDLE.
      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      sri_ready_reg <= 1'b0;
      sri_rdata_reg <= '0;
      sri_error_reg <= 1'b0;
    end else begin
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      sri_ready_reg <= sri_ready_next;
      sri_rdata_reg <= sri_rdata_next;
      sri_error_reg <= sri_error_next;
    end
  end

  assign m_awaddr_o  = addr_reg;
  assign m_araddr_o  = addr_reg;
  assign m_awvalid_o = awvalid_reg;
  assign m_wdata_o   = wdata_reg;
  assign m_wstrb_o   = wstrb_reg;
  assign m_wvalid_o  = wvalid_reg;
  assign m_bready_o  = bready_reg;
  assign m_arvalid_o = arvalid_reg;
  assign m_rready_o  = rready_reg;
  assign sri_ready_o = sri_ready_reg;
  assign sri_rdata_o = sri_rdata_reg;
  assign sri_error_o = sri_error_reg;

endmodule

// File: tb/tb_sri_to_axilite.sv
// Self-checking bench for sri_to_axilite: configurable-latency AXI slave,
// scoreboard queues for AXI address/data and SRI responses.
module tb_sri_to_axilite;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sri_en_i;
  logic [19:0] sri_addr_i;
  logic        sri_we_i;
  logic [63:0] sri_wdata_i;
  logic [7:0]  sri_be_i;
  logic        sri_ready_o;
  logic [63:0] sri_rdata_o;
  logic        sri_error_o;
  logic [31:0] m_awaddr_o;
  logic        m_awvalid_o;
  logic        m_awready_i;
  logic [63:0] m_wdata_o;
  logic [7:0]  m_wstrb_o;
  logic        m_wvalid_o;
  logic        m_wready_i;
  logic [1:0]  m_bresp_i;
  logic        m_bvalid_i;
  logic        m_bready_o;
  logic [31:0] m_araddr_o;
  logic        m_arvalid_o;
  logic        m_arready_i;
  logic [63:0] m_rdata_i;
  logic [1:0]  m_rresp_i;
  logic        m_rvalid_i;
  logic        m_rready_o;

  sri_to_axilite dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sri_en_i(sri_en_i), .sri_addr_i(sri_addr_i), .sri_we_i(sri_we_i),
    .sri_wdata_i(sri_wdata_i), .sri_be_i(sri_be_i),
    .sri_ready_o(sri_ready_o), .sri_rdata_o(sri_rdata_o), .sri_error_o(sri_error_o),
    .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o),
    .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i),
    .m_rready_o(m_rready_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Slave configuration
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [63:0] cfg_rdata = 64'h0;

  // Scoreboards
  logic [31:0] exp_addr_q[$];
  logic [71:0] exp_w_q[$];
  logic [64:0] exp_resp_q[$];

  // Monitor statistics
  int   aw_hs = 0, ar_hs = 0, w_hs = 0, b_hs = 0, resp_count = 0;
  int   awv_cycles = 0, wv_cycles = 0;
  int   ready_cyc = 0, req_rise_cyc = 0, start_cyc = 0, n_issued = 0;
  logic req_prev = 1'b0;
  logic req_now;
  logic [71:0] w_exp;
  logic [64:0] r_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // AXI slave: each ready/valid rises after the configured number of
  // cycles that the master has been waiting on that channel.
  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    m_awready_i = 0; m_wready_i = 0; m_arready_i = 0;
    m_bvalid_i = 0; m_bresp_i = 0; m_rvalid_i = 0; m_rresp_i = 0; m_rdata_i = 0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i) begin
        m_awready_i = 0; m_wready_i = 0; m_arready_i = 0;
        m_bvalid_i = 0; m_rvalid_i = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      end else begin
        if (m_awvalid_o) begin m_awready_i = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin m_awready_i = 0; aw_cnt = 0; end
        if (m_wvalid_o) begin m_wready_i = (w_cnt >= w_delay); w_cnt++; end
        else begin m_wready_i = 0; w_cnt = 0; end
        if (m_arvalid_o) begin m_arready_i = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin m_arready_i = 0; ar_cnt = 0; end
        if (m_bready_o) begin m_bvalid_i = (b_cnt >= b_delay); m_bresp_i = cfg_resp; b_cnt++; end
        else begin m_bvalid_i = 0; b_cnt = 0; end
        if (m_rready_o) begin
          m_rvalid_i = (r_cnt >= r_delay); m_rresp_i = cfg_resp; m_rdata_i = cfg_rdata; r_cnt++;
        end else begin m_rvalid_i = 0; r_cnt = 0; end
      end
    end
  end

  // Monitor: compares handshakes and completions against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m_awvalid_o) awv_cycles++;
      if (m_wvalid_o) wv_cycles++;
      req_now = m_awvalid_o | m_arvalid_o;
      if (req_now && !req_prev) req_rise_cyc = cyc;
      req_prev = req_now;
      if (m_awvalid_o && m_awready_i) begin
        aw_hs++;
        if (exp_addr_q.size() == 0) check("aw_unexpected", 64'(1), 64'(0));
        else check("awaddr", 64'(m_awaddr_o), 64'(exp_addr_q.pop_front()));
      end
      if (m_arvalid_o && m_arready_i) begin
        ar_hs++;
        if (exp_addr_q.size() == 0) check("ar_unexpected", 64'(1), 64'(0));
        else check("araddr", 64'(m_araddr_o), 64'(exp_addr_q.pop_front()));
      end
      if (m_wvalid_o && m_wready_i) begin
        w_hs++;
        if (exp_w_q.size() == 0) check("w_unexpected", 64'(1), 64'(0));
        else begin
          w_exp = exp_w_q.pop_front();
          check("wdata", m_wdata_o, w_exp[71:8]);
          check("wstrb", 64'(m_wstrb_o), 64'(w_exp[7:0]));
        end
      end
      if (m_bvalid_i && m_bready_o) b_hs++;
      if (sri_ready_o) begin
        resp_count++;
        ready_cyc = cyc;
        if (exp_resp_q.size() == 0) check("resp_unexpected", 64'(1), 64'(0));
        else begin
          r_exp = exp_resp_q.pop_front();
          check("sri_rdata", sri_rdata_o, r_exp[63:0]);
          check("sri_error", 64'(sri_error_o), 64'(r_exp[64]));
        end
        $display("txn done cycle=%0d rdata=0x%016h error=%0b", cyc, sri_rdata_o, sri_error_o);
      end
    end
  end

  task automatic start_txn(input logic we, input logic [19:0] addr, input logic [63:0] wdata,
                           input logic [7:0] be, input logic [1:0] resp, input logic [63:0] rdata);
    logic err;
    err = (resp == 2'b10) || (resp == 2'b11);
    cfg_resp = resp;
    cfg_rdata = rdata;
    exp_addr_q.push_back({12'h000, addr});
    if (we) begin
      exp_w_q.push_back({wdata, be});
      exp_resp_q.push_back({err, 64'h0});
    end else begin
      exp_resp_q.push_back({err, err ? 64'h0 : rdata});
    end
    sri_en_i = 1'b1; sri_we_i = we; sri_addr_i = addr; sri_wdata_i = wdata; sri_be_i = be;
    start_cyc = cyc;
    awv_cycles = 0;
    wv_cycles = 0;
    n_issued++;
  endtask

  // Returns at the IDLE cycle following the completion pulse.
  task automatic wait_done(output int lat);
    int n0;
    n0 = resp_count;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i); #1;
      if (resp_count > n0) begin
        lat = ready_cyc - start_cyc;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle_cycle();
    sri_en_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    int lat, b0, rdy_a;
    rst_i = 1'b1;
    sri_en_i = 0; sri_addr_i = 0; sri_we_i = 0; sri_wdata_i = 0; sri_be_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_sri_ready", 64'(sri_ready_o), 64'(0));
    check("rst_sri_rdata", sri_rdata_o, 64'h0);
    check("rst_sri_error", 64'(sri_error_o), 64'(0));
    check("rst_valids", 64'({m_awvalid_o, m_wvalid_o, m_arvalid_o}), 64'(0));
    check("rst_readys", 64'({m_bready_o, m_rready_o}), 64'(0));
    check("rst_awaddr", 64'(m_awaddr_o), 64'(0));
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Zero-wait write
    start_txn(1'b1, 20'h00010, 64'hDEADBEEF_CAFEF00D, 8'hFF, 2'b00, 64'h0);
    wait_done(lat);
    check("wr_latency", 64'(lat), 64'(3));
    idle_cycle();

    // Write with awready delayed by 4 cycles
    aw_delay = 4;
    b0 = b_hs;
    start_txn(1'b1, 20'h00ABC, 64'h1122334455667788, 8'h0F, 2'b00, 64'h0);
    wait_done(lat);
    check("dly_awvalid_cycles", 64'(awv_cycles), 64'(5));
    check("dly_wvalid_cycles", 64'(wv_cycles), 64'(1));
    check("dly_b_count", 64'(b_hs - b0), 64'(1));
    check("dly_latency", 64'(lat), 64'(7));
    aw_delay = 0;
    idle_cycle();

    // Zero-wait read, then verify the data holds afterwards
    start_txn(1'b0, 20'h00020, 64'h0, 8'h00, 2'b00, 64'h0123456789ABCDEF);
    wait_done(lat);
    check("rd_latency", 64'(lat), 64'(3));
    idle_cycle();
    idle_cycle();
    check("rdata_hold", sri_rdata_o, 64'h0123456789ABCDEF);

    // Error reads, EXOKAY read, then a clean write clears the error
    start_txn(1'b0, 20'h00030, 64'h0, 8'h00, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(lat);
    idle_cycle();
    start_txn(1'b0, 20'h00038, 64'h0, 8'h00, 2'b11, 64'hA5A5_A5A5_A5A5_A5A5);
    wait_done(lat);
    idle_cycle();
    start_txn(1'b0, 20'hFFFF8, 64'h0, 8'h00, 2'b01, 64'h0BAD_F00D_1234_5678);
    wait_done(lat);
    idle_cycle();
    start_txn(1'b1, 20'h00040, 64'h0, 8'h00, 2'b00, 64'h0);
    wait_done(lat);
    idle_cycle();

    // W before AW with be=0, and write SLVERR with W late
    aw_delay = 2;
    start_txn(1'b1, 20'h00048, 64'hCCCC_0000_DDDD_1111, 8'h00, 2'b00, 64'h0);
    wait_done(lat);
    check("w_first_latency", 64'(lat), 64'(5));
    aw_delay = 0; w_delay = 3; b_delay = 2;
    idle_cycle();
    start_txn(1'b1, 20'h00050, 64'h5555_6666_7777_8888, 8'h81, 2'b10, 64'h0);
    wait_done(lat);
    check("aw_first_latency", 64'(lat), 64'(8));
    w_delay = 0; b_delay = 0;
    idle_cycle();

    // Back-to-back with sri_en_i held high
    start_txn(1'b1, 20'h00060, 64'h0102030405060708, 8'hF0, 2'b00, 64'h0);
    wait_done(lat);
    rdy_a = ready_cyc;
    start_txn(1'b0, 20'h00068, 64'h0, 8'h00, 2'b00, 64'h1111_2222_3333_4444);
    wait_done(lat);
    check("b2b_gap", 64'(req_rise_cyc - rdy_a), 64'(2));
    check("b2b_latency", 64'(lat), 64'(3));
    idle_cycle();
    idle_cycle();
    check("no_duplicate", 64'(aw_hs + ar_hs), 64'(n_issued));
    check("w_b_balance", 64'(w_hs), 64'(b_hs));

    // Reset during RD_RESP
    r_delay = 1000;
    start_txn(1'b0, 20'h00070, 64'h0, 8'h00, 2'b00, 64'h9999_9999_9999_9999);
    for (int i = 0; i < 50 && !m_rready_o; i++) begin
      @(posedge clk_i); #1;
    end
    check("rst_test_rready_seen", 64'(m_rready_o), 64'(1));
    #2;
    rst_i = 1'b1;
    sri_en_i = 1'b0;
    #1;
    check("async_rst_rready", 64'(m_rready_o), 64'(0));
    check("async_rst_arvalid", 64'(m_arvalid_o), 64'(0));
    check("async_rst_sri_ready", 64'(sri_ready_o), 64'(0));
    check("async_rst_rdata", sri_rdata_o, 64'h0);
    exp_resp_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    r_delay = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("post_rst_idle", 64'({m_awvalid_o, m_wvalid_o, m_arvalid_o, sri_ready_o}), 64'(0));
    end
    start_txn(1'b1, 20'h00080, 64'hFEED_FACE_0BAD_BEEF, 8'h3C, 2'b00, 64'h0);
    wait_done(lat);
    check("post_rst_wr_latency", 64'(lat), 64'(3));
    idle_cycle();
    check("queues_drained", 64'(exp_addr_q.size() + exp_w_q.size() + exp_resp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sri_to_axilite.md
Name: sri_to_axilite

Overview:
SRI-slave to AXI4-Lite-master bridge; the opposite direction of axilite_to_sri. Debug-side logic (e.g. system bus access from the debug module) issues single-beat SRI reads and writes. The bridge turns each one into one AXI4-Lite transaction toward the system interconnect and returns the data and error status. One outstanding transaction at a time; no bursts, no reordering.

Parameters:
SRI_ADDR_WIDTH, 20, SRI byte-address width; must be <= AXI_ADDR_WIDTH
SRI_DATA_WIDTH, 64, SRI data width; must equal AXI_DATA_WIDTH
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI data width
AXI_BASE_ADDR, 0, constant ORed onto the zero-extended SRI address

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
sri_en_i  in  1  request valid; held with addr/we/wdata/be stable until sri_ready_o
sri_addr_i  in  SRI_ADDR_WIDTH  byte address
sri_we_i  in  1  1=write, 0=read
sri_wdata_i  in  SRI_DATA_WIDTH  write data
sri_be_i  in  SRI_DATA_WIDTH/8  byte enables
sri_ready_o  out  1  one-cycle completion pulse
sri_rdata_o  out  SRI_DATA_WIDTH  read data, valid with sri_ready_o
sri_error_o  out  1  transaction error, valid with sri_ready_o
m_awaddr_o  out  AXI_ADDR_WIDTH  write address
m_awvalid_o  out  1  write address valid
m_awready_i  in  1  write address ready
m_wdata_o  out  AXI_DATA_WIDTH  write data
m_wstrb_o  out  AXI_DATA_WIDTH/8  write strobes
m_wvalid_o  out  1  write data valid
m_wready_i  in  1  write data ready
m_bresp_i  in  2  write response
m_bvalid_i  in  1  write response valid
m_bready_o  out  1  write response ready
m_araddr_o  out  AXI_ADDR_WIDTH  read address
m_arvalid_o  out  1  read address valid
m_arready_i  in  1  read address ready
m_rdata_i  in  AXI_DATA_WIDTH  read data
m_rresp_i  in  2  read response
m_rvalid_i  in  1  read valid
m_rready_o  out  1  read ready

Behaviour:
- Reset (asynchronous, rst_i=1): state IDLE. All valid/ready outputs 0. sri_ready_o=0, sri_error_o=0, sri_rdata_o=0. Address, data and strobe registers are 0.
- All AXI outputs and all SRI outputs are registered. Address = AXI_BASE_ADDR | zero-extended sri_addr_i; no alignment masking.
- IDLE: on sri_en_i=1, latch addr/we/wdata/be, then go to WR_REQ if we=1, else RD_REQ.
- WR_REQ: awvalid=1 and wvalid=1 from the first cycle. Each valid drops the cycle after its own handshake (valid&ready), independently. AW before W, W before AW and both in the same cycle are all legal. When both have handshaken, go to WR_RESP.
- WR_RESP: bready=1. On bvalid: error = bresp[1] (SLVERR/DECERR; EXOKAY is treated as OK); go to DONE.
- RD_REQ: arvalid=1 until arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid: error = rresp[1]; capture rdata if there is no error, else 0; go to DONE.
- DONE: sri_ready_o=1 for exactly one cycle, then IDLE. sri_en_i is ignored in DONE. The earliest next accept is the IDLE cycle after DONE.
- sri_rdata_o and sri_error_o hold their values until the next completion. A write completion sets sri_rdata_o to 0.
- Minimum latency with zero-wait AXI: sri_en_i sampled at cycle 0; AW/W or AR handshake at cycle 1; B/R handshake at cycle 2; sri_ready_o at cycle 3.
- No timeout. A slave that never responds stalls the bridge. Recovery is by reset only.
- Writes with be=0 are still issued, with wstrb=0.
- sri_en_i dropping before sri_ready_o is a requester protocol violation. The transaction already latched still completes.
- Reset mid-transaction: outputs clear immediately and the AXI transaction is abandoned. This is acceptable only because the interconnect is reset from the same source.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, and typedef enum sri2axi_state_t {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE}.
- Single module; no sub-module is warranted.

Test Plan:
- Write addr=0x00010, wdata=0xDEADBEEF_CAFEF00D, be=0xFF, zero-wait slave, bresp=OKAY -> awaddr=0x10, wstrb=0xFF, sri_ready_o at cycle 3, sri_error_o=0.
- Write with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid is held 5 cycles, a single B handshake follows, then sri_ready_o.
- Read addr=0x00020, rdata=0x0123456789ABCDEF, OKAY -> sri_rdata_o=0x0123456789ABCDEF, sri_error_o=0, latency 3 cycles.
- Read with rresp=SLVERR, then a read with DECERR -> sri_error_o=1 and sri_rdata_o=0 for both; a following write with OKAY gives sri_error_o=0.
- Back-to-back requests with sri_en_i held high -> the second transaction's AW/AR valid rises exactly 2 cycles after the first sri_ready_o, with no duplicated transaction.
- rst_i asserted during RD_RESP -> rready, arvalid and sri_ready_o are 0 asynchronously; after release the bridge sits in IDLE and accepts a new write correctly.
